// File: rtl/lut_layer_pipe.sv
// Runtime-programmable layer of NUM_N LUT neurons with one registered valid/ready output stage.
// Define LUT_LAYER_READBACK_EN to add the cfg_re/cfg_rdata/cfg_rvalid table readback port.
module lut_layer_pipe #(
    parameter int unsigned NUM_N  = 4,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned OUT_W  = 1,
    parameter int unsigned NIDX_W = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_N*ADDR_W-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_N*OUT_W-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     cfg_we,
    input  logic [NIDX_W-1:0]        cfg_nsel,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [OUT_W-1:0]         cfg_wdata,
`ifdef LUT_LAYER_READBACK_EN
    input  logic                     cfg_re,
    output logic [OUT_W-1:0]         cfg_rdata,
    output logic                     cfg_rvalid,
`endif
    output logic                     cfg_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [NUM_N-1:0]       wr_en;
    logic [NUM_N*OUT_W-1:0] lut_out;
    logic [NUM_N*OUT_W-1:0] out_data_q;
    logic                   out_valid_q;
    logic                   accept;

`ifdef LUT_LAYER_READBACK_EN
    logic [NUM_N-1:0]       rd_hit;
    logic [NUM_N*OUT_W-1:0] rd_lane;
    logic [OUT_W-1:0]       rd_val;
    logic [OUT_W-1:0]       cfg_rdata_q;
    logic                   cfg_rvalid_q;
`endif

    for (genvar k = 0; k < NUM_N; k++) begin : g_neuron
        logic [DEPTH-1:0][OUT_W-1:0] tbl_q;

        // Extra select bit keeps out-of-range cfg_nsel from aliasing onto a real neuron.
        assign wr_en[k] = cfg_we && ({1'b0, cfg_nsel} == (NIDX_W+1)'(k));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tbl_q <= '0;
            end else if (wr_en[k]) begin
                tbl_q[cfg_addr] <= cfg_wdata;
            end
        end

        assign lut_out[k*OUT_W +: OUT_W] = tbl_q[in_data[k*ADDR_W +: ADDR_W]];

`ifdef LUT_LAYER_READBACK_EN
        assign rd_hit[k] = {1'b0, cfg_nsel} == (NIDX_W+1)'(k);
        assign rd_lane[k*OUT_W +: OUT_W] = wr_en[k] ? cfg_wdata : tbl_q[cfg_addr];
`endif
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= lut_out;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign cfg_busy  = out_valid_q;

`ifdef LUT_LAYER_READBACK_EN
    always_comb begin
        rd_val = '0;
        for (int unsigned k = 0; k < NUM_N; k++) begin
            if (rd_hit[k]) begin
                rd_val = rd_lane[k*OUT_W +: OUT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
        end else begin
            cfg_rvalid_q <= cfg_re;
            if (cfg_re) begin
                cfg_rdata_q <= rd_val;
            end
        end
    end

    assign cfg_rdata  = cfg_rdata_q;
    assign cfg_rvalid = cfg_rvalid_q;
`endif

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Directed self-checking bench for lut_layer_pipe; neuron select widened to 3 bits to reach
// out-of-range selects.
module tb_lut_layer_pipe;

    localparam int unsigned NUM_N  = 4;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned OUT_W  = 1;
    localparam int unsigned NIDX_W = 3;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_N*ADDR_W-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_N*OUT_W-1:0]  out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    cfg_we;
    logic [NIDX_W-1:0]       cfg_nsel;
    logic [ADDR_W-1:0]       cfg_addr;
    logic [OUT_W-1:0]        cfg_wdata;
    logic                    cfg_busy;
`ifdef LUT_LAYER_READBACK_EN
    logic                    cfg_re;
    logic [OUT_W-1:0]        cfg_rdata;
    logic                    cfg_rvalid;
`endif

    int total;
    int bad;

    lut_layer_pipe #(
        .NUM_N  (NUM_N),
        .ADDR_W (ADDR_W),
        .OUT_W  (OUT_W),
        .NIDX_W (NIDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_nsel  (cfg_nsel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
`ifdef LUT_LAYER_READBACK_EN
        .cfg_re    (cfg_re),
        .cfg_rdata (cfg_rdata),
        .cfg_rvalid(cfg_rvalid),
`endif
        .cfg_busy  (cfg_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_addr(input logic [ADDR_W-1:0] a);
        in_data = {NUM_N{a}};
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || cfg_busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: out_valid=%b out_data=%h cfg_busy=%b in_ready=%b want 0 0 0 1",
                     out_valid, out_data, cfg_busy, in_ready);
        end
        rst_n = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        set_addr(6'h3F);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'h0) begin
            bad++;
            $display("FAIL reset_lookup: out_valid=%b out_data=%h want 1 0", out_valid, out_data);
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [ADDR_W-1:0] addrs [4];
        logic [3:0]        exp   [4];
        logic [ADDR_W-1:0] a;
        addrs[0] = 6'h00; addrs[1] = 6'h03; addrs[2] = 6'h3C; addrs[3] = 6'h3F;
        exp[0] = 4'h1; exp[1] = 4'h0; exp[2] = 4'h1; exp[3] = 4'h0;
        // neuron 0: entry is 0 when addr[1:0]==2'b11, else 1
        for (int i = 0; i < 64; i++) begin
            a = i[ADDR_W-1:0];
            cfg_we = 1'b1;
            cfg_nsel = 3'd0;
            cfg_addr = a;
            cfg_wdata = (a[1:0] == 2'b11) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        in_valid = 1'b1;
        set_addr(addrs[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                bad++;
                $display("FAIL stream_%0d: out_valid=%b out_data=%h want 1 %h",
                         i, out_valid, out_data, exp[i]);
            end
            if (i < 3) set_addr(addrs[i+1]);
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_end: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        in_valid = 1'b1;
        out_ready = 1'b0;
        set_addr(6'h03);
        @(negedge clk);
        set_addr(6'h00);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 4'h0 || cfg_busy !== 1'b1) begin
                bad++;
                $display("FAIL hold_%0d: in_ready=%b out_valid=%b out_data=%h busy=%b want 0 1 0 1",
                         i, in_ready, out_valid, out_data, cfg_busy);
            end
            if (i == 2) out_ready = 1'b1;
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'h1) begin
            bad++;
            $display("FAIL bp_replace: out_valid=%b out_data=%h want 1 1", out_valid, out_data);
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== 4'h1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_drain: out_valid=%b out_data=%h in_ready=%b want 0 1 1",
                     out_valid, out_data, in_ready);
        end
    endtask

    task automatic test_collision;
        cfg_we = 1'b1;
        cfg_nsel = 3'd1;
        cfg_addr = 6'h05;
        cfg_wdata = 1'b1;
        in_valid = 1'b1;
        set_addr(6'h05);
        @(negedge clk);
        cfg_we = 1'b0;
        total++;
        if (out_data !== 4'h1) begin
            bad++;
            $display("FAIL collide_old: out_data=%h want 1", out_data);
        end
        @(negedge clk);
        total++;
        if (out_data !== 4'h3) begin
            bad++;
            $display("FAIL collide_new: out_data=%h want 3", out_data);
        end
        // A write while a beat is held must not disturb the registered result.
        in_valid = 1'b0;
        out_ready = 1'b0;
        cfg_we = 1'b1;
        cfg_wdata = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'h3) begin
            bad++;
            $display("FAIL held_vs_write: out_valid=%b out_data=%h want 1 3", out_valid, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bad_nsel_reset;
        for (int n = 4; n < 8; n++) begin
            cfg_we = 1'b1;
            cfg_nsel = n[NIDX_W-1:0];
            cfg_addr = 6'h3F;
            cfg_wdata = 1'b1;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        in_valid = 1'b1;
        set_addr(6'h3F);
        @(negedge clk);
        total++;
        if (out_data !== 4'h0) begin
            bad++;
            $display("FAIL bad_nsel: out_data=%h want 0", out_data);
        end
        out_ready = 1'b0;
        set_addr(6'h00);
        @(negedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_valid: out_valid=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || cfg_busy !== 1'b0 || out_data !== 4'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: out_valid=%b busy=%b out_data=%h in_ready=%b want 0 0 0 1",
                     out_valid, cfg_busy, out_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        set_addr(6'h00);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'h0) begin
            bad++;
            $display("FAIL cleared_00: out_valid=%b out_data=%h want 1 0", out_valid, out_data);
        end
        set_addr(6'h05);
        @(negedge clk);
        total++;
        if (out_data !== 4'h0) begin
            bad++;
            $display("FAIL cleared_05: out_data=%h want 0", out_data);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

`ifdef LUT_LAYER_READBACK_EN
    task automatic test_readback;
        total++;
        if (cfg_rvalid !== 1'b0 || cfg_rdata !== 1'b0) begin
            bad++;
            $display("FAIL rb_idle: rvalid=%b rdata=%b want 0 0", cfg_rvalid, cfg_rdata);
        end
        cfg_we = 1'b1;
        cfg_re = 1'b1;
        cfg_nsel = 3'd2;
        cfg_addr = 6'h2A;
        cfg_wdata = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        cfg_nsel = 3'd5;
        total++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== 1'b1) begin
            bad++;
            $display("FAIL rb_wfirst: rvalid=%b rdata=%b want 1 1", cfg_rvalid, cfg_rdata);
        end
        @(negedge clk);
        cfg_re = 1'b0;
        total++;
        if (cfg_rvalid !== 1'b1 || cfg_rdata !== 1'b0) begin
            bad++;
            $display("FAIL rb_badsel: rvalid=%b rdata=%b want 1 0", cfg_rvalid, cfg_rdata);
        end
        @(negedge clk);
        total++;
        if (cfg_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rb_done: rvalid=%b want 0", cfg_rvalid);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        cfg_we = 1'b0;
        cfg_nsel = '0;
        cfg_addr = '0;
        cfg_wdata = '0;
`ifdef LUT_LAYER_READBACK_EN
        cfg_re = 1'b0;
`endif
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_collision();
        test_bad_nsel_reset();
`ifdef LUT_LAYER_READBACK_EN
        test_readback();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lut_layer_pipe.md
Name: lut_layer_pipe

Overview:
- Parametrised, runtime-programmable layer of LUT neurons: NUM_N independent truth tables, each mapping an ADDR_W-bit input to an OUT_W-bit output.
- Successor to the fixed single-neuron distributed-ROM tables. Tables load through a config port instead of being baked in at generation.
- Output is registered with a valid/ready handshake so layers chain into a latency-controlled pipeline between quantised-input gather logic and the next layer.

Parameters:
- NUM_N, 4, number of neurons in the layer.
- ADDR_W, 6, input address bits per neuron (fan-in × input bit-width).
- OUT_W, 1, output bits per neuron.
- NIDX_W, 2, width of the neuron select; must be ≥ clog2(NUM_N), minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  NUM_N*ADDR_W  neuron k address at bits [k*ADDR_W +: ADDR_W].
- in_valid  in  1  input beat valid.
- in_ready  out  1  layer accepts a beat this cycle.
- out_data  out  NUM_N*OUT_W  neuron k result at bits [k*OUT_W +: OUT_W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output.
- cfg_we  in  1  table write strobe.
- cfg_nsel  in  NIDX_W  neuron being written.
- cfg_addr  in  ADDR_W  table entry.
- cfg_wdata  in  OUT_W  entry value.
- cfg_busy  out  1  high while a beat is held in the output register.

Behaviour:
- Reset (async assert, sync release):
  - all table entries = 0; out_valid = 0; out_data = 0; cfg_busy = 0.
  - in_ready follows its equation: 1 during reset.
- Storage:
  - NUM_N × 2^ADDR_W × OUT_W flops.
  - Lookup is combinational from the tables into a single output register.
- Handshake:
  - in_ready = !out_valid || out_ready (no combinational path from in_valid).
  - Accept when in_valid && in_ready: on the next edge, out_data[k] = table[k][in_data slice k] and out_valid = 1.
  - Latency is exactly 1 cycle. Throughput is 1 beat/cycle while out_ready = 1.
- Hold: if out_valid && !out_ready, out_data and out_valid stay stable and in_ready = 0.
- Drain: if out_ready && out_valid && !(in_valid && in_ready), out_valid clears next edge; out_data holds its last value.
- Simultaneous accept and drain: the new beat replaces the old beat with no bubble.
- Config writes:
  - cfg_we writes table[cfg_nsel][cfg_addr] = cfg_wdata at the edge.
  - A lookup in the same cycle as a write uses the pre-write value; the write is visible from the next cycle.
  - cfg_nsel ≥ NUM_N: write ignored, no state changes.
  - Writes are allowed at any time, including mid-stream. An already-registered out_data is never altered by a later write.
- cfg_busy = out_valid (registered); software uses it to quiesce before reprogramming.
- Reset mid-stream: the held beat is discarded, tables clear, and out_valid drops immediately on rst_n low.

Optional Feature:
- Macro: LUT_LAYER_READBACK_EN.
- When defined:
  - Adds ports cfg_re (in, 1), cfg_rdata (out, OUT_W) and cfg_rvalid (out, 1).
  - cfg_re samples cfg_nsel/cfg_addr. One cycle later cfg_rvalid = 1 and cfg_rdata = the entry value after any same-cycle write, i.e. write-first.
  - If cfg_nsel ≥ NUM_N, cfg_rdata = 0 with cfg_rvalid still 1.
  - Reset values: cfg_rdata = 0, cfg_rvalid = 0.
- When undefined: these ports do not exist and no readback logic is synthesised.

Test Plan:
- Reset then lookup:
  - Stimulus: release rst_n, drive in_valid=1 with all addresses 6'h3F, out_ready=1.
  - Required: next cycle out_valid=1 and out_data=0.
- Program and stream:
  - Stimulus: write neuron 0 with entry = 0 when addr[1:0]==2'b11, else 1 (all 64 entries); then send addresses 6'h00, 6'h03, 6'h3C, 6'h3F back-to-back.
  - Required: neuron 0 outputs 1, 0, 1, 0 on consecutive cycles, 1-cycle latency.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid=1.
  - Required: in_ready=0 for those cycles, out_data stable, and no beat lost or duplicated after out_ready returns to 1.
- Write/lookup collision:
  - Stimulus: cfg_we on neuron 1, addr 6'h05, data 1 (old value 0), in the same cycle as a lookup of 6'h05.
  - Required: that lookup returns 0; the following lookup of 6'h05 returns 1.
- Invalid neuron select and reset mid-stream:
  - Stimulus: write with cfg_nsel=NUM_N, then assert rst_n low while out_valid=1.
  - Required: all tables unchanged by the write; on reset, out_valid=0 immediately and tables read 0 afterwards.
- Readback (LUT_LAYER_READBACK_EN defined):
  - Stimulus: write neuron 2, addr 6'h2A, data 1, with cfg_re asserted in the same cycle.
  - Required: one cycle later cfg_rvalid=1 and cfg_rdata=1.
